// File: rtl/mips_pkg.sv
// Shared MEM-stage encodings, the registered request record and the load-extension helper.
package mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Big-endian lane pick: addr_lo 0 is the most significant byte.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] addr_lo,
                                              input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (addr_lo)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = addr_lo[1] ? word[15:0] : word[31:16];
    case (size)
      SIZE_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port word array: combinational read, per-byte-enabled synchronous write; contents never reset.
module data_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdat,
  output logic [31:0]   rdat
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem_q[idx][8*i +: 8] <= wdat[8*i +: 8];
    end
  end

  assign rdat = mem_q[idx];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: fixed-latency data access with pipeline stall, big-endian byte/half/word lanes.
// Optional MEM_MISALIGN_TRAP_EN flags and suppresses misaligned accesses; otherwise low address bits are masked.
module mem_stage
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   read_data_q, read_data_d;
  req_t          req_q, req_d;
  req_t          in_req, cur;
  logic          misalign_raw, req, enter_done;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdat, ram_rdat;
  logic          unused_addr_hi;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_raw = (mem_read | mem_write) &
                        (((mem_size == SIZE_HALF) & addr[0]) |
                         ((mem_size >= SIZE_WORD) & (addr[1:0] != 2'b00)));
`else
  assign misalign_raw = 1'b0;
`endif

  assign misalign = rst_n & misalign_raw;
  assign req      = rst_n & (mem_read | mem_write) & ~misalign_raw;
  assign stall    = ((state_q == ST_IDLE) & req) | (rst_n & (state_q == ST_BUSY));

  always_comb begin
    in_req.rd    = mem_read;
    in_req.wr    = mem_write;
    in_req.size  = mem_size;
    in_req.uns   = mem_unsigned;
    in_req.addr  = addr;
    in_req.wdata = write_data;
  end

  // Live inputs drive the access only when it completes straight from IDLE (LATENCY == 1).
  assign cur = (state_q == ST_IDLE) ? in_req : req_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    enter_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          req_d = in_req;
          cnt_d = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d    = ST_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d    = ST_DONE;
          enter_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Half/word lanes look only at addr[1] / nothing, which masks the low bits when not trapping.
  always_comb begin
    ram_wdat = cur.wdata;
    ram_we   = 4'b0000;
    case (cur.size)
      SIZE_BYTE: begin
        ram_wdat = {4{cur.wdata[7:0]}};
        ram_we   = 4'b1000 >> cur.addr[1:0];
      end
      SIZE_HALF: begin
        ram_wdat = {2{cur.wdata[15:0]}};
        ram_we   = cur.addr[1] ? 4'b0011 : 4'b1100;
      end
      default: ram_we = 4'b1111;
    endcase
    if (!(rst_n & enter_done & cur.wr)) ram_we = 4'b0000;
  end

  always_comb begin
    read_data_d = read_data_q;
    if (enter_done & cur.rd) begin
      read_data_d = cur.wr ? 32'h0 : load_extend(ram_rdat, cur.addr[1:0], cur.size, cur.uns);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      read_data_q <= '0;
      req_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      req_q       <= req_d;
    end
  end

  data_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_data_ram (
    .clk (clk),
    .we  (ram_we),
    .idx (cur.addr[AW+1:2]),
    .wdat(ram_wdat),
    .rdat(ram_rdat)
  );

  assign read_data      = read_data_q;
  assign unused_addr_hi = ^cur.addr[31:AW+2];

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage against a byte-addressed big-endian memory model.
module tb_mem_stage;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, write_data, read_data;
  logic        stall, misalign;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr),
    .write_data(write_data), .read_data(read_data), .stall(stall), .misalign(misalign)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  bmem [DEPTH*4];
  logic [31:0] rd_model;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: flat byte memory, most significant byte at the lowest address.
  task automatic model_apply(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd);
    int          b;
    int          nb;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    b  = int'(a & 32'(DEPTH*4 - 1));
    b  = b - (b % nb);
    v  = 32'h0;
    if (wr) for (int i = 0; i < nb; i++) bmem[b+i] = 8'(wd >> (8*(nb-1-i)));
    if (rd && wr) rd_model = 32'h0;
    else if (rd) begin
      for (int i = 0; i < nb; i++) v = (v << 8) | 32'(bmem[b+i]);
      if (uns || nb == 4) rd_model = v;
      else if (nb == 1) rd_model = {{24{v[7]}}, v[7:0]};
      else rd_model = {{16{v[15]}}, v[15:0]};
    end
  endtask

  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input bit toggle,
                        input bit use_k, input logic [31:0] k);
    int n;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns; addr = a; write_data = wd;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00)) begin
      @(negedge clk);
      check("misalign_flag", {31'b0, misalign}, 32'h1);
      check("misalign_stall", {31'b0, stall}, 32'h0);
      check("misalign_hold", read_data, rd_model);
      return;
    end
`endif
    model_apply(rd, wr, sz, uns, a, wd);
    exp_q.push_back(use_k ? k : rd_model);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (toggle && LAT >= 2 && n == 2) addr = a ^ 32'h0000_0100;
    end while (stall && n < 50);
    if (stall) begin
      checks++; errors++;
      $display("FAIL stall_timeout: stall still high after %0d cycles, expected low", n);
    end
  endtask

  initial begin : monitor
    int scnt = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) scnt = 0;
      else if (stall) scnt++;
      else if (scnt > 0) begin
        check("stall_cycles", 32'(scnt), 32'(LAT));
        check("done_misalign", {31'b0, misalign}, 32'h0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got a completion, expected none");
        end else check("read_data", read_data, exp_q.pop_front());
        scnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [1:0]  sz;
    logic [31:0] a;
    rd_model = 32'h0;
    rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2;
    mem_unsigned = 1'b0; addr = 32'h10; write_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_read_data", read_data, 32'h0);
    check("reset_stall", {31'b0, stall}, 32'h0);
    check("reset_misalign", {31'b0, misalign}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'b0, stall}, 32'h0);

    access(0, 1, 2'd2, 0, 32'h10, 32'h12345678, 0, 1, 32'h0);
    access(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, 1, 32'h12345678);
    access(1, 0, 2'd0, 0, 32'h11, 32'h0, 0, 1, 32'h00000034);
    access(1, 0, 2'd0, 1, 32'h10, 32'h0, 0, 1, 32'h00000012);
    access(1, 0, 2'd1, 0, 32'h12, 32'h0, 0, 1, 32'h00005678);
    access(1, 0, 2'd1, 1, 32'h10, 32'h0, 0, 1, 32'h00001234);
    access(0, 1, 2'd0, 0, 32'h13, 32'hF0, 0, 1, 32'h00001234);
    access(1, 0, 2'd0, 0, 32'h13, 32'h0, 0, 1, 32'hFFFFFFF0);
    access(1, 0, 2'd0, 1, 32'h13, 32'h0, 0, 1, 32'h000000F0);
    access(1, 0, 2'd2, 0, 32'h10, 32'h0, 0, 1, 32'h123456F0);
    access(0, 1, 2'd2, 0, 32'h400, 32'hDEADBEEF, 0, 1, 32'h123456F0);
    access(1, 0, 2'd2, 0, 32'h0, 32'h0, 1, 1, 32'hDEADBEEF);
    access(1, 0, 2'd2, 0, 32'h12, 32'h0, 0, 1, 32'h123456F0);
    access(1, 0, 2'd1, 0, 32'h13, 32'h0, 0, 1, 32'h000056F0);
    access(1, 1, 2'd2, 0, 32'h14, 32'hCAFEF00D, 0, 1, 32'h0);
    access(1, 0, 2'd2, 0, 32'h14, 32'h0, 0, 1, 32'hCAFEF00D);
    access(1, 0, 2'd3, 1, 32'h10, 32'h0, 0, 1, 32'h123456F0);

    for (int i = 0; i < 16; i++) access(0, 1, 2'd2, 0, 32'(i*4), $urandom, 0, 0, 32'h0);

    // Abort a store by resetting while it is still BUSY.
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b1; mem_size = 2'd2; addr = 32'h20; write_data = 32'hBAD0BAD0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; mem_write = 1'b0;
    rd_model = 32'h0;
    @(negedge clk);
    check("abort_read_data", read_data, 32'h0);
    check("abort_stall", {31'b0, stall}, 32'h0);
    access(1, 0, 2'd2, 0, 32'h20, 32'h0, 0, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      r  = 32'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom << 10) | 32'($urandom_range(0, 63));
      access(r >= 4, r <= 3 || r == 9, sz, 1'($urandom_range(0, 1)), a, $urandom,
             1'($urandom_range(0, 1)), 0, 32'h0);
    end

    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (5) @(negedge clk);
    check("pending_expectations", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
